writeback_regfile: RTL and testbench

//  Write-back end of the 8-bit CPU datapath. Registers the execute stage's result
//  (destination address + ALU data) into a WB pipeline register, then commits it to a
//  16 x 8 register file one edge later. Two read ports feed the decode/operand stage.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/regfile_array.sv | 37 +++
 rtl/writeback_regfile.sv | 103 ++++++++++
 tb/tb_writeback_regfile.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
//  DATA_W / ADDR_W / NUM_REGS : default register-file geometry
//  REG_ZERO                   : address of the hard-wired zero register
//  opcode_e                   : opcode encodings shared by decode and ALU
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_MOV = 4'h7,
        OP_LDI = 4'h8,
        OP_NOP = 4'hF
    } opcode_e;

endpackage

// File: rtl/regfile_array.sv
// Register-file storage: single write port, two combinational read ports.
// No bypass here; the write-back stage above handles forwarding.
//  i_clk, i_reset : clock, async active-high reset (clears every entry)
//  i_we/i_wa/i_wd : write enable, address, data (commits on rising edge)
//  i_ra_1/i_ra_2  : read addresses
//  o_rd_1/o_rd_2  : read data, straight from storage
module regfile_array #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wd,
    input  logic [AW-1:0] i_ra_1,
    input  logic [AW-1:0] i_ra_2,
    output logic [DW-1:0] o_rd_1,
    output logic [DW-1:0] o_rd_2
);

    localparam int NREGS = 1 << AW;

    logic [DW-1:0] mem_q [NREGS];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (i_we) begin
            mem_q[i_wa] <= i_wd;
        end
    end

    assign o_rd_1 = mem_q[i_ra_1];
    assign o_rd_2 = mem_q[i_ra_2];

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage + register file of the 8-bit CPU.
// Execute results are captured in a WB register, committed to the register
// file one edge later, and bypassed to both read ports while pending.
//  i_clk, i_reset               : clock, async active-high reset
//  i_wr_en/i_write_add/_data    : execute-stage result
//  i_flush                      : kill the result presented this cycle
//  i_rd_add_1/2, o_rd_data_1/2  : combinational read ports (with bypass)
//  o_wb_valid/o_wb_add/o_wb_data: pending WB entry (forwarding source)
//  o_wb_count                   : committed-write counter, wraps
module writeback_regfile #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_write_add,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_rd_add_1,
    input  logic [ADDR_W-1:0] i_rd_add_2,
    output logic [DATA_W-1:0] o_rd_data_1,
    output logic [DATA_W-1:0] o_rd_data_2,
    output logic              o_wb_valid,
    output logic [ADDR_W-1:0] o_wb_add,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [CNT_W-1:0]  o_wb_count
);

    import cpu_pkg::*;

    localparam bit                ZERO_R0  = (R0_ZERO != 0);
    localparam logic [ADDR_W-1:0] ZERO_ADD = ADDR_W'(REG_ZERO);

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_add_q,   wb_add_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              commit_en;
    logic [DATA_W-1:0] rf_rd_1, rf_rd_2;

    // Read priority: zero register, then pending WB entry, then storage.
    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_val,
        input logic              pend_vld,
        input logic [ADDR_W-1:0] pend_add,
        input logic [DATA_W-1:0] pend_data
    );
        if (ZERO_R0 && addr == ZERO_ADD) return '0;
        if (pend_vld && pend_add == addr) return pend_data;
        return rf_val;
    endfunction

    always_comb begin
        // Address/data load every edge; only the valid bit is qualified.
        wb_valid_d = i_wr_en & ~i_flush;
        wb_add_d   = i_write_add;
        wb_data_d  = i_write_data;
        // Writes to the zero register are dropped and not counted.
        commit_en  = wb_valid_q & ~(ZERO_R0 && wb_add_q == ZERO_ADD);
        count_d    = commit_en ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb_valid_q <= 1'b0;
            wb_add_q   <= '0;
            wb_data_q  <= '0;
            count_q    <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_add_q   <= wb_add_d;
            wb_data_q  <= wb_data_d;
            count_q    <= count_d;
        end
    end

    regfile_array #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_rf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (commit_en),
        .i_wa    (wb_add_q),
        .i_wd    (wb_data_q),
        .i_ra_1  (i_rd_add_1),
        .i_ra_2  (i_rd_add_2),
        .o_rd_1  (rf_rd_1),
        .o_rd_2  (rf_rd_2)
    );

    assign o_rd_data_1 = rd_mux(i_rd_add_1, rf_rd_1, wb_valid_q, wb_add_q, wb_data_q);
    assign o_rd_data_2 = rd_mux(i_rd_add_2, rf_rd_2, wb_valid_q, wb_add_q, wb_data_q);
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_add    = wb_add_q;
    assign o_wb_data   = wb_data_q;
    assign o_wb_count  = count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, flush;
    logic [3:0] wa, ra1, ra2;
    logic [7:0] wd;
    logic [7:0] rd1, rd2, wb_data;
    logic [3:0] wb_add;
    logic       wb_valid;
    logic [15:0] cnt;
    // second instance with an ordinary R0
    logic [7:0] z_rd1, z_rd2, z_wb_data;
    logic [3:0] z_wb_add;
    logic       z_wb_valid;
    logic [15:0] z_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_regfile #(.DATA_W(8), .ADDR_W(4), .R0_ZERO(1), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_write_add(wa),
        .i_write_data(wd), .i_flush(flush), .i_rd_add_1(ra1), .i_rd_add_2(ra2),
        .o_rd_data_1(rd1), .o_rd_data_2(rd2), .o_wb_valid(wb_valid),
        .o_wb_add(wb_add), .o_wb_data(wb_data), .o_wb_count(cnt)
    );

    writeback_regfile #(.DATA_W(8), .ADDR_W(4), .R0_ZERO(0), .CNT_W(16)) dut_z (
        .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_write_add(wa),
        .i_write_data(wd), .i_flush(flush), .i_rd_add_1(ra1), .i_rd_add_2(ra2),
        .o_rd_data_1(z_rd1), .o_rd_data_2(z_rd2), .o_wb_valid(z_wb_valid),
        .o_wb_add(z_wb_add), .o_wb_data(z_wb_data), .o_wb_count(z_cnt)
    );

    // Expected response for one cycle; -1 means "not checked".
    typedef struct {
        string nm;
        int    e1, e2, ev, ec, ez;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input string nm, input int e1, input int e2,
                                input int ev, input int ec, input int ez);
        exp_t e;
        e.nm = nm; e.e1 = e1; e.e2 = e2; e.ev = ev; e.ec = ec; e.ez = ez;
        return e;
    endfunction

    task automatic cmp(input string nm, input string fld, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every negedge, judge the outputs of the current cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.e1 >= 0) cmp(e.nm, "rd1",   int'(rd1),      e.e1);
            if (e.e2 >= 0) cmp(e.nm, "rd2",   int'(rd2),      e.e2);
            if (e.ev >= 0) cmp(e.nm, "valid", int'(wb_valid), e.ev);
            if (e.ec >= 0) cmp(e.nm, "count", int'(cnt),      e.ec);
            if (e.ez >= 0) cmp(e.nm, "z_rd1", int'(z_rd1),    e.ez);
        end
    end

    task automatic drive(input bit we, input logic [3:0] a, input logic [7:0] d,
                         input bit fl, input logic [3:0] r1, input logic [3:0] r2);
        wr_en = we; wa = a; wd = d; flush = fl; ra1 = r1; ra2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit we, input logic [3:0] a, input logic [7:0] d,
                        input bit fl, input logic [3:0] r1, input logic [3:0] r2,
                        input exp_t e);
        drive(we, a, d, fl, r1, r2);
        sb.push_back(e);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 4'd0, 8'h00, 0, 4'd0, 4'd0);
        tick();

        // 1: reset behaviour
        step(0, 4'd0, 8'h00, 0, 4'd3, 4'd9, mk("rst_hold", 0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int i = 0; i < 16; i++)
            step(0, 4'd0, 8'h00, 0, 4'(i), 4'(15 - i), mk("rst_rd", 0, 0, 0, 0, -1));

        // 2: single write, bypass then storage
        step(1, 4'd3, 8'hA5, 0, 4'd3, 4'd0, mk("t2_pre", 0, 0, 0, 0, -1));
        step(0, 4'd0, 8'h00, 0, 4'd3, 4'd3, mk("t2_byp", 'hA5, 'hA5, 1, 0, -1));
        step(0, 4'd0, 8'h00, 0, 4'd3, 4'd2, mk("t2_rf", 'hA5, 0, 0, 1, -1));

        // 3: back-to-back writes to R5
        step(1, 4'd5, 8'h11, 0, 4'd5, 4'd3, mk("t3_n0", 0, 'hA5, 0, 1, -1));
        step(1, 4'd5, 8'h22, 0, 4'd5, 4'd3, mk("t3_n1", 'h11, 'hA5, 1, 1, -1));
        step(1, 4'd5, 8'h33, 0, 4'd5, 4'd5, mk("t3_n2", 'h22, 'h22, 1, 2, -1));
        step(0, 4'd0, 8'h00, 0, 4'd5, 4'd5, mk("t3_n3", 'h33, 'h33, 1, 3, -1));
        step(0, 4'd0, 8'h00, 0, 4'd5, 4'd0, mk("t3_n4", 'h33, 0, 0, 4, -1));

        // 4: R0 write dropped (R0_ZERO=1) but kept on the ordinary-R0 instance
        step(1, 4'd0, 8'hFF, 0, 4'd0, 4'd0, mk("t4_n0", 0, 0, 0, 4, 0));
        step(0, 4'd0, 8'h00, 0, 4'd0, 4'd0, mk("t4_n1", 0, 0, 1, 4, 'hFF));
        step(0, 4'd0, 8'h00, 0, 4'd0, 4'd0, mk("t4_n2", 0, 0, 0, 4, 'hFF));

        // 5: flushed write vanishes; flush does not kill the pending entry
        step(1, 4'd7, 8'h3C, 1, 4'd7, 4'd5, mk("t5_fl0", 0, 'h33, 0, 4, -1));
        step(0, 4'd0, 8'h00, 0, 4'd7, 4'd7, mk("t5_fl1", 0, 0, 0, 4, -1));
        step(0, 4'd0, 8'h00, 0, 4'd7, 4'd7, mk("t5_fl2", 0, 0, 0, 4, -1));
        step(1, 4'd6, 8'h66, 0, 4'd6, 4'd7, mk("t5_r6a", 0, 0, 0, 4, -1));
        step(1, 4'd6, 8'h99, 1, 4'd6, 4'd7, mk("t5_r6b", 'h66, 0, 1, 4, -1));
        step(0, 4'd0, 8'h00, 0, 4'd6, 4'd7, mk("t5_r6c", 'h66, 0, 0, 5, -1));

        // 6: reset while R9 is pending drops it and clears everything
        step(1, 4'd9, 8'h77, 0, 4'd9, 4'd3, mk("t6_n0", 0, 'hA5, 0, 5, -1));
        drive(0, 4'd0, 8'h00, 0, 4'd9, 4'd3);
        sb.push_back(mk("t6_pend", 'h77, 'hA5, 1, 5, -1));
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step(0, 4'd0, 8'h00, 0, 4'd9, 4'd3, mk("t6_post", 0, 0, 0, 0, -1));
        step(0, 4'd0, 8'h00, 0, 4'd5, 4'd6, mk("t6_post2", 0, 0, 0, 0, -1));

        // counter wrap: 65536 commits to R1
        for (int i = 0; i < 65536; i++) begin
            drive(1, 4'd1, 8'(i), 0, 4'd1, 4'd0);
            tick();
        end
        step(0, 4'd0, 8'h00, 0, 4'd1, 4'd0, mk("wrap_pre", 'hFF, 0, 1, 65535, -1));
        step(0, 4'd0, 8'h00, 0, 4'd1, 4'd0, mk("wrap", 'hFF, 0, 0, 0, -1));

        @(negedge clk);
        #1;
        if (sb.size() != 0) cmp("sb_drain", "left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
